rp_serial_tx: RTL
=================

# rp_serial_tx

Byte-wide serial transmitter driving the single-wire link toward the RP host, the outbound counterpart of the `data_in` receive path on the rp_testing board. Parent logic pushes bytes through a valid/ready port into a small FIFO. The block serialises each byte as an asynchronous UART frame: one start bit, LSB-first data, optional parity, one stop bit. It runs entirely in the PLL output clock domain and sits between the test logic and the output pad.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit; 434 gives 115200 baud at 50 MHz; legal range is ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `pll_inst1_CLKOUT0`, input, 1: sole clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tx_data`, input, 8: byte to send; sampled on the accept edge.
- `tx_valid`, input, 1: producer has a byte.
- `tx_ready`, output, 1: FIFO not full.
- `tx_line`, output, 1: serial output; idle high.
- `busy`, output, 1: a frame is in progress (state ≠ IDLE).
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Every output is registered.
- Reset values: `tx_line`=1, `busy`=0, `tx_ready`=1, `fifo_count`=0; FIFO pointers cleared; state IDLE; bit counter and baud counter 0.
- Accept: a byte is written into the FIFO on any edge where `tx_valid && tx_ready`.
  - `tx_ready` = !full, registered from the next-state count, so it is never a combinational path from `tx_valid`.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the shift register and go to START.
  - START: `tx_line`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out 8 bits LSB first, each held CLKS_PER_BIT cycles.
  - After DATA, go to PARITY (macro on) or STOP.
  - PARITY: even parity over the 8 bits, held CLKS_PER_BIT cycles.
  - STOP: `tx_line`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Baud counter: runs 0..CLKS_PER_BIT-1 and wraps; advances the bit and state only on wrap.
- Bit counter: 3 bits, 0..7.
- Simultaneous push and pop: `fifo_count` is unchanged and both succeed.
- A push into an empty FIFO in the same edge that IDLE checks for data is not seen until the next edge.
- Full FIFO: `tx_ready`=0 and `tx_valid` is ignored; no overwrite and no error flag.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH)+1 bits wide; full and empty are decided by MSB comparison.
- Reset mid-frame: `tx_line` goes high immediately (asynchronously), the FIFO is flushed, and the partial frame is lost.
- `tx_data` changes while `tx_valid`=0 have no effect.

## Timing
- Pop at edge N: state is START and `tx_line`=0 from N+1.
- Push-to-start latency from an idle, empty FIFO:
  - byte accepted at edge N;
  - IDLE sees it at N+1;
  - `tx_line` falls after edge N+2.
- Frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- Back-to-back frames: the stop bit's last cycle is followed directly by the start bit.
- `busy` rises with the pop edge and falls at the STOP→IDLE edge.
- `fifo_count` updates on the same edge as the push or pop.

## Configuration
- Macro `RP_SERIAL_TX_PARITY_EN`.
  - Defined: PARITY state is compiled in, and an even-parity bit is sent between D7 and stop (11-bit frame).
  - Undefined: no PARITY state and no parity logic (10-bit frame, 8N1).

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset: hold `rst_n`=0 -> `tx_line`=1, `busy`=0, `tx_ready`=1, `fifo_count`=0.
- Single byte 0xA5 pushed while idle -> `tx_line` reads, in 4-cycle bits, 0 | 1,0,1,0,0,1,0,1 | 1.
  - Frame is 40 cycles (44 with parity, parity bit = 0).
  - `busy` is high for exactly the frame.
- Push 0x00, 0xFF, 0x3C back-to-back -> three contiguous frames with no idle cycle between a stop and the following start; `fifo_count` peaks at 2.
- Push 6 bytes with `tx_valid` held high while the first frame is active:
  - `tx_ready` drops after the FIFO fills at 4 entries;
  - the remaining bytes are accepted only as pops free entries;
  - all 6 bytes are transmitted in order.
- Simultaneous push and pop at a frame boundary -> `fifo_count` is unchanged on that edge and no byte is lost or duplicated.
- Assert `rst_n`=0 mid-D3 of a frame with 2 bytes queued -> `tx_line`=1 without waiting for a clock edge, `fifo_count`=0; after release, nothing is transmitted until a new push.

Source files
------------

// File: rtl/rp_serial_tx.sv
// rp_serial_tx: FIFO-buffered asynchronous serial transmitter (start, 8 data bits LSB first, stop).
// Build option: define RP_SERIAL_TX_PARITY_EN to send an even-parity bit between D7 and stop.
module rp_serial_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          pll_inst1_CLKOUT0,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_line,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef RP_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   baud_r;
  logic [2:0]      bit_r;
  logic [7:0]      shift_r;
`ifdef RP_SERIAL_TX_PARITY_EN
  logic            parity_r;
`endif

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_r;
  logic [PW:0]     rd_ptr_r;
  logic [PW:0]     wr_ptr_s;
  logic [PW:0]     rd_ptr_s;
  logic [7:0]      head_s;
  logic            empty_s;
  logic            full_next_s;
  logic            push_s;
  logic            pop_s;
  logic            baud_wrap_s;

  logic            line_s;
  logic            busy_s;
  logic            tx_line_r;
  logic            busy_r;
  logic            tx_ready_r;
  logic [PW:0]     fifo_count_r;

  assign tx_line    = tx_line_r;
  assign busy       = busy_r;
  assign tx_ready   = tx_ready_r;
  assign fifo_count = fifo_count_r;

  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign push_s      = tx_valid && tx_ready_r;
  assign head_s      = mem_r[rd_ptr_r[PW-1:0]];
  assign baud_wrap_s = (baud_r == BAUD_LAST);

  // Next pointer values; ready and occupancy are registered from these.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_s = wr_ptr_r + (PW+1)'(1'b1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + (PW+1)'(1'b1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
  end

  assign full_next_s = (wr_ptr_s[PW] != rd_ptr_s[PW]) &&
                       (wr_ptr_s[PW-1:0] == rd_ptr_s[PW-1:0]);

  // FIFO storage and pointers.
  always_ff @(posedge pll_inst1_CLKOUT0 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[PW-1:0]] <= tx_data;
      end
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
    end
  end

  // FSM state register.
  always_ff @(posedge pll_inst1_CLKOUT0 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; a pop happens from IDLE or at the last cycle of STOP.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_wrap_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_wrap_s && (bit_r == 3'd7)) begin
`ifdef RP_SERIAL_TX_PARITY_EN
          state_s = ST_PARITY;
`else
          state_s = ST_STOP;
`endif
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef RP_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_wrap_s) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (baud_wrap_s && !empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_START;
        end else if (baud_wrap_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: line level from the current state, busy from the next state.
  always_comb begin
    line_s = 1'b1;
    busy_s = (state_s != ST_IDLE);
    case (state_r)
      ST_IDLE:   line_s = 1'b1;
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = shift_r[0];
`ifdef RP_SERIAL_TX_PARITY_EN
      ST_PARITY: line_s = parity_r;
`endif
      ST_STOP:   line_s = 1'b1;
      default:   line_s = 1'b1;
    endcase
  end

  // Baud counter, bit counter and shift register.
  always_ff @(posedge pll_inst1_CLKOUT0 or negedge rst_n) begin
    if (!rst_n) begin
      baud_r  <= {CW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      if (pop_s || (state_r == ST_IDLE) || baud_wrap_s) begin
        baud_r <= {CW{1'b0}};
      end else begin
        baud_r <= baud_r + CW'(1'b1);
      end

      if ((state_r == ST_DATA) && baud_wrap_s) begin
        bit_r <= bit_r + 3'd1;
      end else if (state_r != ST_DATA) begin
        bit_r <= 3'd0;
      end else begin
        bit_r <= bit_r;
      end

      if (pop_s) begin
        shift_r <= head_s;
      end else if ((state_r == ST_DATA) && baud_wrap_s) begin
        shift_r <= {1'b0, shift_r[7:1]};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

`ifdef RP_SERIAL_TX_PARITY_EN
  // Parity of the byte being sent, captured with the pop.
  always_ff @(posedge pll_inst1_CLKOUT0 or negedge rst_n) begin
    if (!rst_n) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= even_parity(head_s);
    end else begin
      parity_r <= parity_r;
    end
  end
`endif

  // Registered outputs; tx_line returns high the moment rst_n falls.
  always_ff @(posedge pll_inst1_CLKOUT0 or negedge rst_n) begin
    if (!rst_n) begin
      tx_line_r    <= 1'b1;
      busy_r       <= 1'b0;
      tx_ready_r   <= 1'b1;
      fifo_count_r <= {(PW+1){1'b0}};
    end else begin
      tx_line_r    <= line_s;
      busy_r       <= busy_s;
      tx_ready_r   <= !full_next_s;
      fifo_count_r <= wr_ptr_s - rd_ptr_s;
    end
  end

endmodule
